// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding, default bus widths and size encodings.
// Imported by load_store_unit and lsu_byte_lane.
package lsu_pkg;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 16;

  // Encoding of the client 'size' input.
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    MERGE_WR,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane extract (loads) and merge (stores) for a 16-bit word.
// Latency: combinational, no state.
// Backpressure: none; pure function of its inputs.
// Ports: word_i = memory word, byte_hi_i = lane select (1 = [15:8]),
//        sign_ext_i = extend bit 7 of the lane, wbyte_i = byte to insert,
//        load_o = extended lane, merge_o = word_i with the lane replaced.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic              byte_hi_i,
  input  logic              sign_ext_i,
  input  logic [7:0]        wbyte_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0] lane;

  always_comb begin
    lane    = byte_hi_i ? word_i[15:8] : word_i[7:0];
    load_o  = {{(DATA_W-8){sign_ext_i & lane[7]}}, lane};
    merge_o = word_i;
    if (byte_hi_i) merge_o[15:8] = wbyte_i;
    else           merge_o[7:0]  = wbyte_i;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a single-request client to a synchronous data memory.
// Latency from accept edge to done cycle: word store 2, load 3, byte store 4.
// Backpressure: ready is high only when idle; requests while busy are dropped.
// Ports: client side req/we/addr/wdata/size/byte_hi/sign_ext in, ready/done/rdata out;
//        memory side mem_addr/mem_we/mem_wdata out, mem_rdata in (1-cycle read latency).
// Build option: define LSU_BYTE_EN for byte loads (extract/extend) and byte
// stores (read-modify-write); without it every access is a word access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              size,
  input  logic              byte_hi,
  input  logic              sign_ext,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q;
  logic              ready_q, done_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;   // doubles as the latched request address
  logic [DATA_W-1:0] mem_wdata_q;  // doubles as the latched store data
  logic [DATA_W-1:0] rdata_q;
  logic              we_q, byte_q, byte_hi_q, sign_ext_q;

  logic              req_byte;       // incoming request is a byte access
  logic [DATA_W-1:0] rdata_d;        // load result taken from the memory word
  logic [DATA_W-1:0] merge_wdata_d;  // read-modify-write word for byte stores

`ifdef LSU_BYTE_EN
  logic [DATA_W-1:0] byte_load_d;

  assign req_byte = (size == SIZE_BYTE);

  lsu_byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
    .word_i    (mem_rdata),
    .byte_hi_i (byte_hi_q),
    .sign_ext_i(sign_ext_q),
    .wbyte_i   (mem_wdata_q[7:0]),
    .load_o    (byte_load_d),
    .merge_o   (merge_wdata_d)
  );

  assign rdata_d = byte_q ? byte_load_d : mem_rdata;
`else
  logic unused_byte_cfg;

  // Byte controls have no effect in a word-only build.
  assign unused_byte_cfg = ^{size, byte_hi, sign_ext, byte_hi_q, sign_ext_q};
  assign req_byte        = 1'b0;
  assign rdata_d         = mem_rdata;
  assign merge_wdata_d   = mem_wdata_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      byte_hi_q   <= 1'b0;
      sign_ext_q  <= 1'b0;
    end else begin
      // Pulsed outputs fall back to 0 unless the transition below sets them.
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q     <= ISSUE;
            ready_q     <= 1'b0;
            we_q        <= we;
            byte_q      <= req_byte;
            byte_hi_q   <= byte_hi;
            sign_ext_q  <= sign_ext;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
            // A word store writes while in ISSUE, so raise the strobe now.
            mem_we_q    <= we & ~req_byte;
          end
        end
        ISSUE: begin
          if (we_q && !byte_q) begin
            state_q <= RESP;
            done_q  <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // mem_rdata now holds the word addressed during ISSUE.
          if (we_q) begin
            state_q     <= MERGE_WR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_wdata_d;
          end else begin
            state_q <= RESP;
            done_q  <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        MERGE_WR: begin
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 256x16 synchronous memory.
// Latency: n/a (bench).
// Backpressure: waits for ready before every request; all waits are bounded.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, we, size, byte_hi, sign_ext;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ready, done, mem_we;
  logic [15:0] rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .size     (size),
    .byte_hi  (byte_hi),
    .sign_ext (sign_ext),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: write-through on mem_we, registered read with one-cycle latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Issues one request from an idle unit and observes it until done (bounded).
  // lat counts cycles after the accept edge; the done cycle is the last counted.
  task automatic do_op(input logic op_we, input logic [7:0] op_addr,
                       input logic [15:0] op_wdata, input logic op_size,
                       input logic op_hi, input logic op_sx,
                       output int lat, output int we_cnt,
                       output logic [7:0] we_addr, output logic [15:0] we_data,
                       output logic [15:0] rd);
    we = op_we; addr = op_addr; wdata = op_wdata;
    size = op_size; byte_hi = op_hi; sign_ext = op_sx;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; we_cnt = 0; we_addr = '0; we_data = '0;
    while (1) begin
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (done || lat >= 12) break;
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    @(posedge clk); #1;  // RESP -> IDLE
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 16'h0000;
    size = 1'b0; byte_hi = 1'b0; sign_ext = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
  endtask

  task automatic test_word_store();
    int lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    do_op(1'b1, 8'h01, 16'h00AA, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wstore_latency got=%0d exp=2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL wstore_we_cycles got=%0d exp=1", wc); end
    checks++; if (wa !== 8'h01) begin errors++; $display("FAIL wstore_addr got=%h exp=01", wa); end
    checks++; if (mem[8'h01] !== 16'h00AA) begin errors++; $display("FAIL wstore_mem got=%h exp=00aa", mem[8'h01]); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wstore_rdata_kept got=%h exp=0000", rd); end
  endtask

  task automatic test_word_load();
    int lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    do_op(1'b0, 8'h01, 16'h0000, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wload_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h00AA) begin errors++; $display("FAIL wload_rdata got=%h exp=00aa", rd); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL wload_we_cycles got=%0d exp=0", wc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_addr !== 8'h01 || rdata !== 16'h00AA) begin
      errors++; $display("FAIL idle_hold got addr=%h rdata=%h exp addr=01 rdata=00aa", mem_addr, rdata);
    end
  endtask

  task automatic test_addr_ff();
    int lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    do_op(1'b1, 8'hFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (wa !== 8'hFF || wd !== 16'h5A5A) begin
      errors++; $display("FAIL ff_store got addr=%h data=%h exp addr=ff data=5a5a", wa, wd);
    end
    do_op(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL ff_load got=%h exp=5a5a", rd); end
    do_op(1'b1, 8'h02, 16'h1357, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL store_keeps_rdata got=%h exp=5a5a", rd); end
  endtask

`ifdef LSU_BYTE_EN
  task automatic test_byte_ops();
    int lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    mem[8'h05] = 16'h1234;
    do_op(1'b1, 8'h05, 16'h0080, 1'b1, 1'b1, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bstore_latency got=%0d exp=4", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL bstore_we_cycles got=%0d exp=1", wc); end
    checks++; if (mem[8'h05] !== 16'h8034) begin errors++; $display("FAIL bstore_mem got=%h exp=8034", mem[8'h05]); end
    do_op(1'b0, 8'h05, 16'h0000, 1'b1, 1'b1, 1'b1, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'hFF80 || lat !== 3) begin
      errors++; $display("FAIL bload_sext got=%h lat=%0d exp=ff80 lat=3", rd, lat);
    end
    do_op(1'b0, 8'h05, 16'h0000, 1'b1, 1'b1, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'h0080) begin errors++; $display("FAIL bload_zext got=%h exp=0080", rd); end
    do_op(1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b1, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'h0034) begin errors++; $display("FAIL bload_lo got=%h exp=0034", rd); end
  endtask
`else
  task automatic test_byte_ops();
    int lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    mem[8'h05] = 16'h1234;
    do_op(1'b1, 8'h05, 16'hBEEF, 1'b1, 1'b1, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL size_ignored_latency got=%0d exp=2", lat); end
    checks++; if (mem[8'h05] !== 16'hBEEF) begin errors++; $display("FAIL size_ignored_mem got=%h exp=beef", mem[8'h05]); end
    do_op(1'b0, 8'h05, 16'h0000, 1'b1, 1'b1, 1'b1, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL size_ignored_load got=%h exp=beef", rd); end
  endtask
`endif

  task automatic test_back_to_back();
    int first_done = 0, second_done = 0, dones = 0, wes = 0;
    logic ready_at4 = 1'b0, ready_leak = 1'b0;
    we = 1'b0; addr = 8'h01; size = 1'b0; byte_hi = 1'b0; sign_ext = 1'b0;
    req = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = cyc; else second_done = cyc;
      end
      if (mem_we) wes++;
      if (cyc == 4) ready_at4 = ready;
      else if (cyc <= 7 && ready) ready_leak = 1'b1;
      if (cyc == 5) req = 1'b0;
    end
    checks++; if (first_done !== 3 || second_done !== 7) begin
      errors++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=3,7", first_done, second_done);
    end
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    checks++; if (ready_at4 !== 1'b1 || ready_leak !== 1'b0) begin
      errors++; $display("FAIL b2b_ready got at4=%b busy_high=%b exp at4=1 busy_high=0", ready_at4, ready_leak);
    end
    checks++; if (wes !== 0) begin errors++; $display("FAIL b2b_mem_we got=%0d exp=0", wes); end
  endtask

  task automatic test_reset_abort();
    int dones = 0, wes = 0, lat, wc; logic [7:0] wa; logic [15:0] wd, rd;
    mem[8'h07] = 16'h1111;
    addr = 8'h07; wdata = 16'h0022; byte_hi = 1'b0; sign_ext = 1'b0;
`ifdef LSU_BYTE_EN
    we = 1'b1; size = 1'b1;
`else
    we = 1'b0; size = 1'b0;
`endif
    req = 1'b1;
    @(posedge clk); #1;   // ISSUE
    req = 1'b0;
    @(posedge clk); #1;   // WAIT
    rst = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL abort_state got ready=%b done=%b mem_we=%b exp 1/0/0", ready, done, mem_we);
    end
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      if (mem_we) wes++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0 || wes !== 0) begin
      errors++; $display("FAIL abort_quiet got done=%0d we=%0d exp 0/0", dones, wes);
    end
    checks++; if (mem[8'h07] !== 16'h1111) begin errors++; $display("FAIL abort_mem got=%h exp=1111", mem[8'h07]); end
    do_op(1'b0, 8'h01, 16'h0000, 1'b0, 1'b0, 1'b0, lat, wc, wa, wd, rd);
    checks++; if (rd !== 16'h00AA || lat !== 3) begin
      errors++; $display("FAIL abort_recover got=%h lat=%0d exp=00aa lat=3", rd, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    test_reset();
    test_word_store();
    test_word_load();
    test_addr_ff();
    test_byte_ops();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
